issue_queue: RTL and testbench

Decoupling FIFO between the scoreboard's issue port and the register renaming stage. Holds up to DEPTH decoded `scoreboard_entry_t` instructions so that decode can keep issuing while rename and read-operands are stalled. It presents the oldest entry downstream with the same valid/ack protocol that the rename stage consumes. Both flush inputs empty the queue without disturbing architectural state.

---
 rtl/ariane_pkg.sv | 16 +
 rtl/issue_queue.sv | 50 +++++
 tb/tb_issue_queue.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// ariane_pkg: shared scoreboard entry type and issue queue sizing
package ariane_pkg;
  localparam int unsigned ISSUE_QUEUE_DEPTH = 4;
  typedef struct packed {
    logic [63:0] pc;
    logic [2:0]  trans_id;
    logic [3:0]  fu;
    logic [7:0]  op;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rd;
    logic [63:0] result;
    logic        valid;
    logic        use_imm;
  } scoreboard_entry_t;
endpackage

// File: rtl/issue_queue.sv
// issue_queue: decoupling FIFO of scoreboard entries between issue and rename
module issue_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = ISSUE_QUEUE_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     flush_unissued_instr_i,
  input  scoreboard_entry_t        issue_instr_i,
  input  logic                     issue_instr_valid_i,
  output logic                     issue_ack_o,
  output scoreboard_entry_t        issue_instr_o,
  output logic                     issue_instr_valid_o,
  input  logic                     issue_ack_i,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0] cnt_q, cnt_d;
  scoreboard_entry_t mem_q [DEPTH];
  logic flush, push, pop;
  always_comb begin
    flush = flush_i | flush_unissued_instr_i;
    issue_ack_o = (cnt_q != (PW+1)'(DEPTH)) && !flush;
    issue_instr_valid_o = cnt_q != '0;
    issue_instr_o = issue_instr_valid_o ? mem_q[rd_ptr_q] : '0;
    push = issue_instr_valid_i && issue_ack_o;
    pop = issue_ack_i && issue_instr_valid_o && !flush;
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
    cnt_d = flush ? '0 : cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    count_o = cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= issue_instr_i;
  end
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: randomized scoreboard check of issue_queue against a queue model
module tb_issue_queue;
  import ariane_pkg::*;
  localparam int unsigned DEPTH = ISSUE_QUEUE_DEPTH;
  localparam int EW = $bits(scoreboard_entry_t);
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic flush_i = 1'b0;
  logic flush_unissued_instr_i = 1'b0;
  scoreboard_entry_t issue_instr_i = '0;
  logic issue_instr_valid_i = 1'b0;
  logic issue_ack_o;
  scoreboard_entry_t issue_instr_o;
  logic issue_instr_valid_o;
  logic issue_ack_i = 1'b0;
  logic [$clog2(DEPTH):0] count_o;
  int checks = 0;
  int fails = 0;
  bit armed = 1'b0;
  scoreboard_entry_t model [$];
  issue_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .flush_unissued_instr_i(flush_unissued_instr_i),
    .issue_instr_i(issue_instr_i),
    .issue_instr_valid_i(issue_instr_valid_i),
    .issue_ack_o(issue_ack_o),
    .issue_instr_o(issue_instr_o),
    .issue_instr_valid_o(issue_instr_valid_o),
    .issue_ack_i(issue_ack_i),
    .count_o(count_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  function automatic scoreboard_entry_t mk(input logic [63:0] pc);
    logic [191:0] r;
    scoreboard_entry_t e;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    e = r[EW-1:0];
    e.pc = pc;
    return e;
  endfunction
  always @(negedge clk) begin
    bit fl, exp_ack;
    fl = flush_i || flush_unissued_instr_i;
    exp_ack = model.size() < DEPTH && !fl;
    if (armed) begin
      check("count", EW'(count_o), EW'(model.size()));
      check("valid", EW'(issue_instr_valid_o), EW'(model.size() != 0));
      check("ack_o", EW'(issue_ack_o), EW'(exp_ack));
      check("head", issue_instr_o, model.size() != 0 ? model[0] : '0);
    end
    if (rst_i) begin
      model.delete();
      armed = 1'b1;
    end else if (fl) model.delete();
    else begin
      if (issue_ack_i && model.size() != 0) void'(model.pop_front());
      if (issue_instr_valid_i && exp_ack) model.push_back(issue_instr_i);
    end
  end
  task automatic step(input bit rst, input bit v, input logic [63:0] pc, input bit ack, input bit fl, input bit flu);
    rst_i = rst;
    issue_instr_valid_i = v;
    issue_instr_i = mk(pc);
    issue_ack_i = ack;
    flush_i = fl;
    flush_unissued_instr_i = flu;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [63:0] pc;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 64'h100 + 64'(4 * i), 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0);
    pc = 64'h300;
    for (int i = 0; i < 2; i++) begin
      step(0, 1, pc, 0, 0, 0);
      pc += 4;
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 1, pc, 1, 0, 0);
      pc += 4;
    end
    step(0, 1, pc, 0, 0, 0);
    step(0, 1, 64'hdead, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 64'h400 + 64'(4 * i), 0, 0, 0);
    step(0, 1, 64'hbeef, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 64'h500, 0, 0, 0);
    step(0, 1, 64'h504, 0, 0, 0);
    step(1, 1, 64'h508, 0, 0, 0);
    step(0, 1, 64'h200, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 79) == 0, $urandom_range(0, 9) < 7, 64'($urandom),
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
